// File: rtl/ma_stage_hs.sv
// ma_stage_hs: RV32I memory-access stage with a handshaked data-memory port and the MEM/WB register.
// Optional MA_MISALIGN_TRAP_EN: misaligned half/word accesses are suppressed and flagged on WB_misalign.
//
// state | meaning
// IDLE  | nothing outstanding; a memory op in MEM requests combinationally
// REQ   | request held with stable fields, waiting for grant
// RSP   | load granted, waiting for rvalid
module ma_stage_hs #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int WBS_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,

  input  logic             MEM_valid,
  input  logic             MEM_rd_wren,
  input  logic             MEM_mem_wren,
  input  logic             MEM_mem_rden,
  input  logic             MEM_insn_vld,
  input  logic [2:0]       MEM_funct3,
  input  logic [WBS_W-1:0] MEM_wb_sel,
  input  logic [XLEN-1:0]  MEM_alu_data,
  input  logic [XLEN-1:0]  MEM_rs2_data,
  input  logic [XLEN-1:0]  MEM_pc,
  input  logic [XLEN-1:0]  MEM_inst,
  input  logic [RA_W-1:0]  MEM_rd_addr,

  output logic             o_mem_stall,

  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [XLEN-1:0]  o_dmem_addr,
  output logic [XLEN-1:0]  o_dmem_wdata,
  output logic [3:0]       o_dmem_be,
  input  logic             i_dmem_gnt,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,

  output logic [WBS_W-1:0] WB_wb_sel,
  output logic             WB_rd_wren,
  output logic             WB_insn_vld,
  output logic [XLEN-1:0]  WB_alu_data,
  output logic [XLEN-1:0]  WB_ld_data,
  output logic [XLEN-1:0]  WB_pc,
  output logic [XLEN-1:0]  WB_inst,
  output logic [RA_W-1:0]  WB_rd_addr,
  output logic             WB_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t state_q;

  logic            mem_op;
  logic            is_store;
  logic            is_byte;
  logic            is_half;
  logic            misalign;
  logic            op_eff;
  logic [1:0]      lane;
  logic            gnt_ok;
  logic            ld_done;
  logic            done;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] ld_aligned;
  logic [XLEN-1:0] ld_data_d;
  logic            rd_wren_d;

  logic [WBS_W-1:0] wb_sel_q;
  logic             rd_wren_q;
  logic             insn_vld_q;
  logic [XLEN-1:0]  alu_data_q;
  logic [XLEN-1:0]  ld_data_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  inst_q;
  logic [RA_W-1:0]  rd_addr_q;
  logic             misalign_q;

  assign mem_op   = MEM_valid & (MEM_mem_wren | MEM_mem_rden);
  assign is_store = MEM_mem_wren;
  assign is_byte  = (MEM_funct3[1:0] == 2'b00);
  assign is_half  = (MEM_funct3[1:0] == 2'b01);

`ifdef MA_MISALIGN_TRAP_EN
  assign misalign = mem_op & ((is_half & MEM_alu_data[0]) |
                              (~is_byte & ~is_half & (MEM_alu_data[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign op_eff = mem_op & ~misalign;

  // Byte lane of the access; half and word lanes are forced aligned.
  assign lane = is_byte ? MEM_alu_data[1:0] :
                is_half ? {MEM_alu_data[1], 1'b0} : 2'b00;

  // Upstream holds MEM_* while stalled, so request fields stay stable in REQ.
  assign o_dmem_req  = ~i_rst & op_eff & (state_q != RSP);
  assign o_dmem_we   = is_store;
  assign o_dmem_addr = {MEM_alu_data[XLEN-1:2], 2'b00};

  always_comb begin
    o_dmem_be    = 4'b1111;
    o_dmem_wdata = MEM_rs2_data;
    if (is_byte) begin
      o_dmem_be    = 4'b0001 << lane;
      o_dmem_wdata = {4{MEM_rs2_data[7:0]}};
    end else if (is_half) begin
      o_dmem_be    = 4'b0011 << lane;
      o_dmem_wdata = {2{MEM_rs2_data[15:0]}};
    end
  end

  assign gnt_ok      = o_dmem_req & i_dmem_gnt;
  assign ld_done     = (state_q == RSP) & i_dmem_rvalid;
  assign done        = (gnt_ok & is_store) | ld_done;
  assign o_mem_stall = ~i_rst & op_eff & ~done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_eff) begin
            if (!i_dmem_gnt)   state_q <= REQ;
            else if (!is_store) state_q <= RSP;
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            if (is_store) state_q <= IDLE;
            else          state_q <= RSP;
          end
        end
        RSP: begin
          if (i_dmem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rshift = i_dmem_rdata >> {lane, 3'b000};

  always_comb begin
    case (MEM_funct3)
      3'b000:  ld_aligned = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
      3'b100:  ld_aligned = {{(XLEN-8){1'b0}}, rshift[7:0]};
      3'b001:  ld_aligned = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      3'b101:  ld_aligned = {{(XLEN-16){1'b0}}, rshift[15:0]};
      default: ld_aligned = i_dmem_rdata;
    endcase
  end

  // Response data only enters WB on the completing rvalid; otherwise zero.
  assign ld_data_d = ld_done ? ld_aligned : '0;
  assign rd_wren_d = MEM_rd_wren & ~misalign;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_sel_q   <= '0;
      rd_wren_q  <= 1'b0;
      insn_vld_q <= 1'b0;
      alu_data_q <= '0;
      ld_data_q  <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      rd_addr_q  <= '0;
      misalign_q <= 1'b0;
    end else if (o_mem_stall) begin
      insn_vld_q <= 1'b0;
      rd_wren_q  <= 1'b0;
    end else begin
      wb_sel_q   <= MEM_wb_sel;
      rd_wren_q  <= rd_wren_d;
      insn_vld_q <= MEM_insn_vld;
      alu_data_q <= MEM_alu_data;
      ld_data_q  <= ld_data_d;
      pc_q       <= MEM_pc;
      inst_q     <= MEM_inst;
      rd_addr_q  <= MEM_rd_addr;
      misalign_q <= misalign;
    end
  end

  assign WB_wb_sel   = wb_sel_q;
  assign WB_rd_wren  = rd_wren_q;
  assign WB_insn_vld = insn_vld_q;
  assign WB_alu_data = alu_data_q;
  assign WB_ld_data  = ld_data_q;
  assign WB_pc       = pc_q;
  assign WB_inst     = inst_q;
  assign WB_rd_addr  = rd_addr_q;
  assign WB_misalign = misalign_q;

endmodule

// File: tb/tb_ma_stage_hs.sv
// tb_ma_stage_hs: randomized instruction stream against a transaction-level model of the MEM stage.
// Honours MA_MISALIGN_TRAP_EN the same way the design does.
module tb_ma_stage_hs;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int WBS_W = 2;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             MEM_valid, MEM_rd_wren, MEM_mem_wren, MEM_mem_rden, MEM_insn_vld;
  logic [2:0]       MEM_funct3;
  logic [WBS_W-1:0] MEM_wb_sel;
  logic [XLEN-1:0]  MEM_alu_data, MEM_rs2_data, MEM_pc, MEM_inst;
  logic [RA_W-1:0]  MEM_rd_addr;
  logic             o_mem_stall, o_dmem_req, o_dmem_we;
  logic [XLEN-1:0]  o_dmem_addr, o_dmem_wdata;
  logic [3:0]       o_dmem_be;
  logic             i_dmem_gnt, i_dmem_rvalid;
  logic [XLEN-1:0]  i_dmem_rdata;
  logic [WBS_W-1:0] WB_wb_sel;
  logic             WB_rd_wren, WB_insn_vld, WB_misalign;
  logic [XLEN-1:0]  WB_alu_data, WB_ld_data, WB_pc, WB_inst;
  logic [RA_W-1:0]  WB_rd_addr;

  ma_stage_hs #(.XLEN(XLEN), .RA_W(RA_W), .WBS_W(WBS_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .MEM_valid(MEM_valid), .MEM_rd_wren(MEM_rd_wren), .MEM_mem_wren(MEM_mem_wren),
    .MEM_mem_rden(MEM_mem_rden), .MEM_insn_vld(MEM_insn_vld), .MEM_funct3(MEM_funct3),
    .MEM_wb_sel(MEM_wb_sel), .MEM_alu_data(MEM_alu_data), .MEM_rs2_data(MEM_rs2_data),
    .MEM_pc(MEM_pc), .MEM_inst(MEM_inst), .MEM_rd_addr(MEM_rd_addr),
    .o_mem_stall(o_mem_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .WB_wb_sel(WB_wb_sel), .WB_rd_wren(WB_rd_wren), .WB_insn_vld(WB_insn_vld),
    .WB_alu_data(WB_alu_data), .WB_ld_data(WB_ld_data), .WB_pc(WB_pc), .WB_inst(WB_inst),
    .WB_rd_addr(WB_rd_addr), .WB_misalign(WB_misalign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  wb_sel;
    logic        rd_wren;
    logic        insn_vld;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        mis;
  } wb_t;

  wb_t         exp_wb, exp_wb_nx;
  logic        exp_stall, exp_req, exp_we, exp_st;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        chk_on = 1'b0;
  logic        chk_stall_en = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;

  int          cap_stalls;
  logic        cap_req, cap_we, cap_stable;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Access size in bytes, lane offset within the word, and lane data.
  function automatic int acc_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = acc_bytes(f3);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int n;
    logic [31:0] v;
    n = acc_bytes(f3);
    v = w >> (8 * lane_off(f3, a));
    if (n == 1) begin
      v &= 32'h0000_00FF;
      if (!f3[2] && v[7]) v |= 32'hFFFF_FF00;
    end else if (n == 2) begin
      v &= 32'h0000_FFFF;
      if (!f3[2] && v[15]) v |= 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int n, off;
    be  = '0;
    n   = acc_bytes(f3);
    off = lane_off(f3, a);
    for (int i = 0; i < n; i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = acc_bytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  always @(negedge i_clk) begin
    if (chk_on) begin
      if (chk_stall_en) chk("stall", {31'd0, o_mem_stall}, {31'd0, exp_stall});
      chk("req", {31'd0, o_dmem_req}, {31'd0, exp_req});
      if (exp_req) begin
        chk("we", {31'd0, o_dmem_we}, {31'd0, exp_we});
        chk("addr", o_dmem_addr, exp_addr);
        if (exp_st) begin
          chk("be", {28'd0, o_dmem_be}, {28'd0, exp_be});
          chk("wdata", o_dmem_wdata, exp_wdata);
        end
      end
      chk("wb_sel", {30'd0, WB_wb_sel}, {30'd0, exp_wb.wb_sel});
      chk("wb_rd_wren", {31'd0, WB_rd_wren}, {31'd0, exp_wb.rd_wren});
      chk("wb_insn_vld", {31'd0, WB_insn_vld}, {31'd0, exp_wb.insn_vld});
      chk("wb_alu", WB_alu_data, exp_wb.alu);
      chk("wb_ld", WB_ld_data, exp_wb.ld);
      chk("wb_pc", WB_pc, exp_wb.pc);
      chk("wb_inst", WB_inst, exp_wb.inst);
      chk("wb_rd", {27'd0, WB_rd_addr}, {27'd0, exp_wb.rd});
      chk("wb_mis", {31'd0, WB_misalign}, {31'd0, exp_wb.mis});
    end
  end

  // One instruction held in MEM until done: grant after g wait cycles, response k cycles after grant.
  task automatic issue(input logic v, input logic wr, input logic rd, input logic ivld,
                       input logic rdw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int g, input int k, input logic [31:0] rdat);
    logic op, st, mis, eff, rsp, last;
    int len;
    op  = v & (wr | rd);
    st  = wr;
    mis = 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
    mis = op && ((int'(a[1:0]) % acc_bytes(f3)) != 0);
`endif
    eff = op & ~mis;
    len = !eff ? 1 : (st ? g + 1 : g + k + 1);
    MEM_valid = v; MEM_mem_wren = wr; MEM_mem_rden = rd; MEM_insn_vld = ivld;
    MEM_rd_wren = rdw; MEM_funct3 = f3; MEM_alu_data = a; MEM_rs2_data = d;
    MEM_wb_sel = 2'($urandom); MEM_pc = $urandom; MEM_inst = $urandom;
    MEM_rd_addr = 5'($urandom);
    cap_stalls = 0;
    cap_stable = 1'b1;
    for (int c = 0; c < len; c++) begin
      rsp  = eff && !st && (c > g);
      last = (c == len - 1);
      i_dmem_gnt    = eff && (c == g);
      i_dmem_rvalid = rsp ? last : 1'($urandom);
      i_dmem_rdata  = (rsp && last) ? rdat : $urandom;
      exp_stall = eff && !last;
      exp_req   = eff && (c <= g);
      exp_we    = st;
      exp_st    = st;
      exp_addr  = {a[31:2], 2'b00};
      exp_be    = store_be(f3, a);
      exp_wdata = store_wd(f3, d);
      if (exp_stall) begin
        exp_wb_nx          = exp_wb;
        exp_wb_nx.insn_vld = 1'b0;
        exp_wb_nx.rd_wren  = 1'b0;
      end else begin
        exp_wb_nx.wb_sel   = MEM_wb_sel;
        exp_wb_nx.rd_wren  = rdw & ~mis;
        exp_wb_nx.insn_vld = ivld;
        exp_wb_nx.alu      = a;
        exp_wb_nx.ld       = (rsp && last) ? load_val(f3, a, rdat) : 32'd0;
        exp_wb_nx.pc       = MEM_pc;
        exp_wb_nx.inst     = MEM_inst;
        exp_wb_nx.rd       = MEM_rd_addr;
        exp_wb_nx.mis      = mis;
      end
      #3;
      if (o_mem_stall) cap_stalls++;
      if (c == 0) begin
        cap_req = o_dmem_req; cap_we = o_dmem_we; cap_addr = o_dmem_addr;
        cap_be = o_dmem_be; cap_wdata = o_dmem_wdata;
      end else if (o_dmem_req && (o_dmem_addr !== cap_addr || o_dmem_be !== cap_be ||
                                  o_dmem_wdata !== cap_wdata || o_dmem_we !== cap_we)) begin
        cap_stable = 1'b0;
      end
      @(posedge i_clk); #1;
      exp_wb = exp_wb_nx;
    end
  endtask

  task automatic clear_mem();
    MEM_valid = 0; MEM_mem_wren = 0; MEM_mem_rden = 0; MEM_insn_vld = 0; MEM_rd_wren = 0;
    MEM_funct3 = 3'b010; MEM_wb_sel = '0; MEM_alu_data = '0; MEM_rs2_data = '0;
    MEM_pc = '0; MEM_inst = '0; MEM_rd_addr = '0;
    i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = '0;
  endtask

  // One reset cycle; optionally with a granted store sitting in MEM to show the request is gated.
  task automatic do_reset(input logic keep_op);
    clear_mem();
    i_rst = 1'b1;
    MEM_valid = keep_op; MEM_mem_wren = keep_op; MEM_alu_data = 32'h0000_0200;
    i_dmem_gnt = keep_op;
    exp_req = 1'b0; exp_stall = 1'b0; chk_stall_en = 1'b0;
    exp_wb_nx = '0;
    #3;
    chk("rst_req_gated", {31'd0, o_dmem_req}, 32'd0);
    @(posedge i_clk); #1;
    exp_wb = exp_wb_nx;
    chk_on = 1'b1;
    i_rst = 1'b0;
    clear_mem();
    chk_stall_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic       r_v, r_wr, r_rd;
  logic [2:0] r_f3;
  int         r_kind;

  initial begin
    exp_wb = '0; exp_wb_nx = '0;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_st = 0;
    exp_addr = '0; exp_wdata = '0; exp_be = '0;
    do_reset(1'b1);
    chk("rst_wb_vld", {31'd0, WB_insn_vld}, 32'd0);
    chk("rst_wb_pc", WB_pc, 32'd0);

    // SW 0xDEADBEEF -> 0x100, granted immediately
    issue(1, 1, 0, 1, 0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1, 32'd0);
    chk("sw_be", {28'd0, cap_be}, 32'h0000_000F);
    chk("sw_addr", cap_addr, 32'h0000_0100);
    chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("sw_stalls", cap_stalls, 0);
    chk("sw_wb_vld", {31'd0, WB_insn_vld}, 32'd1);

    // SB 0xA5 -> 0x103
    issue(1, 1, 0, 1, 0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 1, 32'd0);
    chk("sb_be", {28'd0, cap_be}, 32'h0000_0008);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

    // LB / LBU from 0x102, response two cycles after grant
    issue(1, 0, 1, 1, 1, 3'b000, 32'h0000_0102, 32'd0, 0, 2, 32'h0080_FF00);
    chk("lb_stalls", cap_stalls, 2);
    chk("lb_data", WB_ld_data, 32'hFFFF_FF80);
    chk("lb_wb_vld", {31'd0, WB_insn_vld}, 32'd1);
    issue(1, 0, 1, 1, 1, 3'b100, 32'h0000_0102, 32'd0, 0, 2, 32'h0080_FF00);
    chk("lbu_data", WB_ld_data, 32'h0000_0080);

    // SH with three grant wait cycles
    issue(1, 1, 0, 1, 0, 3'b001, 32'h0000_0202, 32'hABCD_1234, 3, 1, 32'd0);
    chk("sh_stalls", cap_stalls, 3);
    chk("sh_stable", {31'd0, cap_stable}, 32'd1);
    chk("sh_be", {28'd0, cap_be}, 32'h0000_000C);
    chk("sh_wdata", cap_wdata, 32'h1234_1234);

    // Reset while a load waits in RSP, then a late rvalid
    clear_mem();
    MEM_valid = 1; MEM_mem_rden = 1; MEM_funct3 = 3'b010; MEM_alu_data = 32'h0000_0040;
    MEM_insn_vld = 1; MEM_rd_wren = 1; i_dmem_gnt = 1;
    exp_stall = 1; exp_req = 1; exp_we = 0; exp_st = 0; exp_addr = 32'h0000_0040;
    exp_wb_nx = exp_wb; exp_wb_nx.insn_vld = 0; exp_wb_nx.rd_wren = 0;
    @(posedge i_clk); #1;
    exp_wb = exp_wb_nx;
    do_reset(1'b0);
    i_dmem_rvalid = 1; i_dmem_rdata = 32'hFFFF_FFFF;
    exp_stall = 0; exp_req = 0; exp_wb_nx = '0;
    @(posedge i_clk); #1;
    exp_wb = exp_wb_nx;
    i_dmem_rvalid = 0;
    chk("late_rv_ld", WB_ld_data, 32'd0);
    chk("late_rv_vld", {31'd0, WB_insn_vld}, 32'd0);
    chk("late_rv_req", {31'd0, o_dmem_req}, 32'd0);

    // LW from 0x101
    issue(1, 0, 1, 1, 1, 3'b010, 32'h0000_0101, 32'd0, 0, 1, 32'h1122_3344);
`ifdef MA_MISALIGN_TRAP_EN
    chk("mis_req", {31'd0, cap_req}, 32'd0);
    chk("mis_flag", {31'd0, WB_misalign}, 32'd1);
    chk("mis_rd_wren", {31'd0, WB_rd_wren}, 32'd0);
`else
    chk("lw101_req", {31'd0, cap_req}, 32'd1);
    chk("lw101_addr", cap_addr, 32'h0000_0100);
    chk("lw101_mis", {31'd0, WB_misalign}, 32'd0);
    chk("lw101_data", WB_ld_data, 32'h1122_3344);
`endif

    for (int i = 0; i < 400; i++) begin
      r_v    = ($urandom_range(0, 9) != 0);
      r_kind = $urandom_range(0, 99);
      if (r_kind < 40) begin
        r_wr = 0; r_rd = 1; r_f3 = 3'($urandom);
      end else if (r_kind < 75) begin
        r_wr = 1; r_rd = ($urandom_range(0, 9) == 0); r_f3 = 3'($urandom_range(0, 2));
      end else begin
        r_wr = 0; r_rd = 0; r_f3 = 3'($urandom);
      end
      issue(r_v, r_wr, r_rd, 1'($urandom), 1'($urandom), r_f3, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
